// File: rtl/addsub_arb_pkg.sv
// Shared types and helpers for the two-requester, nibble-serial add/subtract unit.
package addsub_arb_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // One full-adder stage; returns {carry_out, sum}.
    function automatic logic [1:0] fulladd(input logic a, input logic b, input logic ci);
        logic s;
        logic co;
        s  = a ^ b ^ ci;
        co = (a & b) | (ci & (a ^ b));
        return {co, s};
    endfunction

endpackage

// File: rtl/nibble_alu.sv
// One 4-bit add/subtract slice: y is inverted when sub is set, carry-in is a separate input.
module nibble_alu
    import addsub_arb_pkg::*;
(
    input  logic               sub_i,
    input  logic               cin_i,
    input  logic [SLICE_W-1:0] x_i,
    input  logic [SLICE_W-1:0] y_i,
    output logic [SLICE_W-1:0] s_o,
    output logic               cout_o
);

    logic [SLICE_W-1:0] y_inv_s;
    logic [SLICE_W:0]   c_s;

    // Ripple the carry through four full-adder stages.
    always_comb begin
        y_inv_s  = y_i ^ {SLICE_W{sub_i}};
        c_s      = '0;
        s_o      = '0;
        c_s[0]   = cin_i;
        for (int i = 0; i < int'(SLICE_W); i++) begin
            {c_s[i+1], s_o[i]} = fulladd(x_i[i], y_inv_s[i], c_s[i]);
        end
        cout_o   = c_s[SLICE_W];
    end

endmodule

// File: rtl/addsub_arb.sv
// Round-robin arbiter in front of a nibble-serial adder/subtractor shared by two requesters.
module addsub_arb
    import addsub_arb_pkg::*;
#(
    parameter  int unsigned NIBBLES = 4,
    localparam int unsigned W       = SLICE_W * NIBBLES
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [1:0]   req_i,
    input  logic [1:0]   sub_i,
    input  logic [W-1:0] a0_i,
    input  logic [W-1:0] b0_i,
    input  logic [W-1:0] a1_i,
    input  logic [W-1:0] b1_i,
    output logic [1:0]   gnt_o,
    output logic         busy_o,
    output logic [1:0]   done_o,
    output logic [W-1:0] result_o,
    output logic         cout_o,
    output logic         ovf_o
);

    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e             state_q, state_d;
    logic               last_q;
    logic               id_q;
    logic               sub_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic [SLICE_W-1:0] a_q   [NIBBLES];
    logic [SLICE_W-1:0] b_q   [NIBBLES];
    logic [SLICE_W-1:0] res_q [NIBBLES];
    logic               cout_q;
    logic               ovf_q;

    logic [1:0]         gnt_s;
    logic               sel_s;
    logic [W-1:0]       a_sel_s;
    logic [W-1:0]       b_sel_s;
    logic               last_slice_s;
    logic [SLICE_W-1:0] alu_x_s;
    logic [SLICE_W-1:0] alu_y_s;
    logic [SLICE_W-1:0] alu_s_s;
    logic               alu_co_s;
    logic               msb_cin_s;

    assign a_sel_s      = sel_s ? a1_i : a0_i;
    assign b_sel_s      = sel_s ? b1_i : b0_i;
    assign last_slice_s = (idx_q == LAST_IDX);
    assign alu_x_s      = a_q[idx_q];
    assign alu_y_s      = b_q[idx_q];
    // Carry into the sign bit, recovered from the sign-bit sum and its two operands.
    assign msb_cin_s    = alu_x_s[SLICE_W-1] ^ alu_y_s[SLICE_W-1] ^ sub_q ^ alu_s_s[SLICE_W-1];

    nibble_alu u_nibble_alu (
        .sub_i  (sub_q),
        .cin_i  (carry_q),
        .x_i    (alu_x_s),
        .y_i    (alu_y_s),
        .s_o    (alu_s_s),
        .cout_o (alu_co_s)
    );

    // Round-robin pick: a tie goes to the requester that was not served last.
    always_comb begin
        gnt_s = 2'b00;
        sel_s = 1'b0;
        if (state_q == ST_IDLE) begin
            case (req_i)
                2'b01:   begin gnt_s = 2'b01; sel_s = 1'b0; end
                2'b10:   begin gnt_s = 2'b10; sel_s = 1'b1; end
                2'b11:   begin
                    sel_s = ~last_q;
                    gnt_s = last_q ? 2'b01 : 2'b10;
                end
                default: begin gnt_s = 2'b00; sel_s = 1'b0; end
            endcase
        end else begin
            gnt_s = 2'b00;
        end
    end

    // Next-state logic for IDLE -> CALC (NIBBLES cycles) -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_i) state_d = ST_CALC;
                else        state_d = ST_IDLE;
            end
            ST_CALC: begin
                if (last_slice_s) state_d = ST_DONE;
                else              state_d = ST_CALC;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, captured operands, and the slice-serial datapath.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < int'(NIBBLES); k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                res_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (|req_i) begin
                        id_q    <= sel_s;
                        last_q  <= sel_s;
                        sub_q   <= sub_i[sel_s];
                        carry_q <= sub_i[sel_s];
                        idx_q   <= '0;
                        for (int k = 0; k < int'(NIBBLES); k++) begin
                            a_q[k] <= a_sel_s[k*SLICE_W +: SLICE_W];
                            b_q[k] <= b_sel_s[k*SLICE_W +: SLICE_W];
                        end
                    end
                end
                ST_CALC: begin
                    res_q[idx_q] <= alu_s_s;
                    carry_q      <= alu_co_s;
                    if (last_slice_s) begin
                        idx_q  <= '0;
                        cout_q <= alu_co_s;
                        ovf_q  <= msb_cin_s ^ alu_co_s;
                    end else begin
                        idx_q  <= idx_q + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    idx_q <= '0;
                end
                default: begin
                    idx_q <= '0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < int'(NIBBLES); g++) begin : g_result
        assign result_o[g*SLICE_W +: SLICE_W] = res_q[g];
    end

    assign gnt_o  = gnt_s;
    assign busy_o = (state_q != ST_IDLE);
    assign done_o = (state_q == ST_DONE) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_addsub_arb.sv
// Randomized self-checking bench for addsub_arb against an arithmetic reference model.
module tb_addsub_arb;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk;
    logic         rst_n;
    logic [1:0]   req;
    logic [1:0]   sub;
    logic [W-1:0] a0, b0, a1, b1;
    logic [1:0]   gnt;
    logic         busy;
    logic [1:0]   done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int prev_gnt_cyc = -1;
    int last_srv = 1;

    addsub_arb #(.NIBBLES(NIB)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .req_i    (req),
        .sub_i    (sub),
        .a0_i     (a0),
        .b0_i     (b0),
        .a1_i     (a1),
        .b1_i     (b1),
        .gnt_o    (gnt),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result),
        .cout_o   (cout),
        .ovf_o    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands captured at grant.
    task automatic model(input logic [W-1:0] ea, input logic [W-1:0] eb, input logic es,
                         output logic [W-1:0] er, output logic ec, output logic eo);
        int ua, ub, sa, sb, u, s;
        ua = int'(ea);
        ub = int'(eb);
        sa = int'($signed(ea));
        sb = int'($signed(eb));
        if (es) begin
            u  = ua - ub;
            s  = sa - sb;
            ec = (ua >= ub);
        end else begin
            u  = ua + ub;
            s  = sa + sb;
            ec = (u > 65535);
        end
        er = W'(u);
        eo = (s > 32767) || (s < -32768);
    endtask

    // One full transaction starting at a negedge in IDLE, ending at the negedge of the following IDLE cycle.
    task automatic txn(input logic [1:0] rq, input logic [1:0] sb,
                       input logic [W-1:0] xa0, input logic [W-1:0] xb0,
                       input logic [W-1:0] xa1, input logic [W-1:0] xb1,
                       input bit scramble, input bit chk_gap);
        int          w;
        logic [W-1:0] ea, eb, er;
        logic        es, ec, eo;
        req = rq; sub = sb; a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1;
        #1;
        if (rq == 2'b11)      w = (last_srv == 1) ? 0 : 1;
        else if (rq == 2'b10) w = 1;
        else                  w = 0;
        check_eq("gnt", gnt, 32'(2'b01 << w));
        if (chk_gap && prev_gnt_cyc >= 0) check_eq("gnt_spacing", cyc - prev_gnt_cyc, NIB + 2);
        prev_gnt_cyc = cyc;
        last_srv = w;
        ea = (w == 1) ? xa1 : xa0;
        eb = (w == 1) ? xb1 : xb0;
        es = sb[w];
        model(ea, eb, es, er, ec, eo);
        for (int c = 1; c <= NIB; c++) begin
            @(negedge clk);
            check_eq("busy_calc", busy, 1);
            check_eq("gnt_calc", gnt, 0);
            check_eq("done_calc", done, 0);
            if (scramble) begin
                req = 2'($urandom); sub = 2'($urandom);
                a0 = W'($urandom); b0 = W'($urandom);
                a1 = W'($urandom); b1 = W'($urandom);
            end
        end
        @(negedge clk);
        check_eq("done", done, 32'(2'b01 << w));
        check_eq("busy_done", busy, 1);
        check_eq("gnt_done", gnt, 0);
        check_eq("result", result, er);
        check_eq("cout", cout, ec);
        check_eq("ovf", ovf, eo);
        req = 2'b00;
        @(negedge clk);
        check_eq("done_idle", done, 0);
        check_eq("busy_idle", busy, 0);
        check_eq("result_hold", result, er);
    endtask

    initial begin
        rst_n = 1'b0;
        req = 2'b00; sub = 2'b00;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_gnt", gnt, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_cout", cout, 0);
        check_eq("rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Both requesting back to back: alternating grants, fixed spacing.
        for (int i = 0; i < 4; i++)
            txn(2'b11, 2'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'b0, 1'b1);

        txn(2'b01, 2'b00, 16'h1234, 16'h0FFF, 16'h0000, 16'h0000, 1'b0, 1'b0);
        txn(2'b10, 2'b10, 16'hAAAA, 16'hBBBB, 16'h0000, 16'h0001, 1'b1, 1'b0);
        txn(2'b10, 2'b10, 16'h0000, 16'h0000, 16'h0005, 16'h0003, 1'b1, 1'b0);
        txn(2'b01, 2'b00, 16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0);
        txn(2'b01, 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b0);
        txn(2'b01, 2'b01, 16'h8000, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b0);

        // Reset during the second CALC cycle aborts the operation.
        req = 2'b01; sub = 2'b00; a0 = 16'h1111; b0 = 16'h2222;
        #1;
        check_eq("abort_gnt", gnt, 1);
        @(negedge clk);
        @(negedge clk);
        req = 2'b00;
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_result", result, 0);
        check_eq("abort_cout", cout, 0);
        check_eq("abort_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        last_srv = 1;
        for (int c = 0; c < NIB + 2; c++) begin
            @(negedge clk);
            check_eq("post_abort_done", done, 0);
            check_eq("post_abort_busy", busy, 0);
        end
        txn(2'b11, 2'b00, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] rq;
            rq = 2'($urandom_range(1, 3));
            txn(rq, 2'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/addsub_arb.md
ADDSUB_ARB -- requirements
Module: addsub_arb

Interface
REQ-001 Parameter NIBBLES, default 4, number of 4-bit slices; operand width W = 4*NIBBLES.
REQ-002 Clock  input  1  single clock; all state updates on rising edge.
REQ-003 Resetn  input  1  reset, asynchronous, active-low.
REQ-004 req  input  2  per-requester level request; bit i = requester i.
REQ-005 sub  input  2  per-requester op select: 0 = add, 1 = subtract (a - b).
REQ-006 a0, b0  input  W each  requester 0 operands.
REQ-007 a1, b1  input  W each  requester 1 operands.
REQ-008 gnt  output  2  one-cycle pulse; operands of granted requester captured this cycle.
REQ-009 busy  output  1  high from the cycle after grant through the DONE cycle.
REQ-010 done  output  2  one-cycle pulse to the requester whose result is valid.
REQ-011 result  output  W  sum or difference of the last completed operation.
REQ-012 cout  output  1  final carry; for subtract, 1 = no borrow (a >= b unsigned).
REQ-013 ovf  output  1  signed two's-complement overflow of the last completed operation.

Function
REQ-014 The FSM SHALL have states IDLE, CALC, DONE.
REQ-015 IDLE: if any req bit high, SHALL assert exactly one gnt bit, latch that requester's a, b, sub, and ID, and go to CALC with slice index 0 and carry = sub.
REQ-016 Arbitration SHALL be round-robin: one requester asserting wins; both asserting -> the requester not served last wins.
REQ-017 CALC: each cycle SHALL process one slice: s = a_k + (b_k XOR {4{sub}}) + carry, write s into result slice k, register slice carry-out as carry.
REQ-018 CALC SHALL last exactly NIBBLES cycles, slice 0 (LSB) first, then go to DONE.
REQ-019 DONE: done[ID] SHALL pulse for one cycle, cout = final carry, ovf = carry into MSB XOR carry out of MSB; next state IDLE.
REQ-020 Latency: gnt cycle T -> done at T+NIBBLES+1; next gnt no earlier than T+NIBBLES+2.
REQ-021 req SHALL be ignored (no gnt) while not in IDLE; requesters hold req until gnt.
REQ-022 result, cout, ovf SHALL update only as stated and hold value until the next operation overwrites them; result slices are not guaranteed stable during CALC.
REQ-023 Operands changing after gnt SHALL not affect the operation in progress.
REQ-024 Wrap-around: results are modulo 2^W; no saturation.

Reset
REQ-025 Resetn low SHALL force IDLE, gnt = 0, done = 0, busy = 0, result = 0, cout = 0, ovf = 0, carry = 0, slice index = 0.
REQ-026 Round-robin pointer SHALL reset to "last served = requester 1", so requester 0 wins the first tie.
REQ-027 Reset asserted mid-CALC SHALL abort the operation with no done pulse; the aborted requester must re-request.

Structure
REQ-028 Shared package SHALL hold state encodings (IDLE, CALC, DONE) and slice width constant 4.
REQ-029 One sub-module nibble_alu (sub, cin, x[3:0], y[3:0], s[3:0], cout) SHALL implement the slice with separate invert and carry-in, built from fulladd stages; instantiated once and reused every CALC cycle.

Verification
REQ-030 Requester 0, add 0x1234 + 0x0FFF -> gnt[0] at T, done[0] at T+5, result 0x2233, cout 0, ovf 0.
REQ-031 Requester 1, subtract 0x0000 - 0x0001 -> result 0xFFFF, cout 0, ovf 0; 0x0005 - 0x0003 -> 0x0002, cout 1.
REQ-032 Add 0x7FFF + 0x0001 -> result 0x8000, ovf 1, cout 0; add 0xFFFF + 0x0001 -> 0x0000, cout 1, ovf 0.
REQ-033 Both req high continuously after reset -> grants alternate 0,1,0,1, spaced 6 cycles apart.
REQ-034 Resetn low during second CALC cycle -> no done, all outputs 0, IDLE next; subsequent req granted normally.
REQ-035 Operands altered and req toggled during busy -> no gnt, result matches operands captured at gnt.
